// File: rtl/interrupt_ack_sequencer_8259a_pkg.sv
// Shared types and one-hot helpers for the 8259A interrupt-acknowledge sequencer.
// The OCW2 command codes follow the {R,SL,EOI} field of the command byte.
package interrupt_ack_sequencer_8259a_pkg;

  typedef enum logic [1:0] {
    ACK_IDLE,
    ACK_PULSE1,
    ACK_PULSE2,
    ACK_PULSE3
  } ack_state_e;

  typedef enum logic [2:0] {
    OCW2_ROT_AEOI_CLR = 3'b000,
    OCW2_NS_EOI       = 3'b001,
    OCW2_NOP          = 3'b010,
    OCW2_SP_EOI       = 3'b011,
    OCW2_ROT_AEOI_SET = 3'b100,
    OCW2_ROT_NS_EOI   = 3'b101,
    OCW2_SET_PRIO     = 3'b110,
    OCW2_ROT_SP_EOI   = 3'b111
  } ocw2_cmd_e;

  function automatic logic [2:0] bit2num(input logic [7:0] onehot);
    logic [2:0] num;
    num = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) num = 3'(i);
    end
    return num;
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] num);
    return 8'b1 << num;
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] wide;
    wide = {value, value} << amount;
    return wide[15:8];
  endfunction

  function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] wide;
    wide = {value, value} >> amount;
    return wide[7:0];
  endfunction

  // Highest priority sits one position above the IR that currently holds lowest priority.
  function automatic logic [7:0] resolv_priority(input logic [7:0] request,
                                                 input logic [2:0] lowest);
    logic [7:0] rotated;
    logic [2:0] first;
    logic       found;
    rotated = rotate_right(request, lowest + 3'd1);
    first   = 3'd0;
    found   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rotated[i]) begin
        first = 3'(i);
        found = 1'b1;
      end
    end
    return found ? num2bit(first + lowest + 3'd1) : 8'h00;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_8259a.sv
// 8259A in-service control path: raises INT, walks the INTA pulse sequence, drives the
// vector/CALL bytes and generates end-of-interrupt and priority-rotation updates.
module interrupt_ack_sequencer_8259a
  import interrupt_ack_sequencer_8259a_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
  parameter logic [7:0] CALL_OPCODE    = 8'hCD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        icw1_write,
  input  logic        ocw2_write,
  input  logic [7:0]  ocw2_data,
  input  logic        mode_8086,
  input  logic        auto_eoi,
  input  logic        call_interval_4,
  input  logic [4:0]  vector_base,
  input  logic [10:0] call_address,
  input  logic        interrupt_acknowledge_n,
  input  logic [7:0]  highest_level_in_request,
  input  logic [7:0]  highest_level_in_service,
  output logic        interrupt,
  output logic        latch_in_service,
  output logic [7:0]  acknowledged_level,
  output logic [7:0]  end_of_interrupt,
  output logic [2:0]  priority_rotate,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_out_enable
);

  ack_state_e state;
  logic       prev_inta;
  logic       rotate_in_aeoi;
  logic       inta_fall;
  logic       inta_rise;
  logic       seq_done;
  logic [2:0] level_num;
  logic [2:0] ocw2_level;
  ocw2_cmd_e  ocw2_cmd;
  logic [7:0] ocw2_eoi;
  logic       ocw2_rot_valid;
  logic [2:0] ocw2_rot_num;
  logic       aeoi_rot_next;
  logic       unused_ocw2_bits;

  assign inta_fall        = prev_inta & ~interrupt_acknowledge_n;
  assign inta_rise        = ~prev_inta & interrupt_acknowledge_n;
  assign level_num        = bit2num(acknowledged_level);
  assign ocw2_level       = ocw2_data[2:0];
  assign ocw2_cmd         = ocw2_cmd_e'(ocw2_data[7:5]);
  assign unused_ocw2_bits = ^ocw2_data[4:3];
  assign seq_done         = inta_rise &&
                            ((state == ACK_PULSE2 && mode_8086) || state == ACK_PULSE3);

  // Non-specific forms only rotate when something is actually in service.
  always_comb begin
    ocw2_eoi       = 8'h00;
    ocw2_rot_valid = 1'b0;
    ocw2_rot_num   = priority_rotate;
    aeoi_rot_next  = rotate_in_aeoi;
    if (ocw2_write) begin
      case (ocw2_cmd)
        OCW2_NS_EOI: ocw2_eoi = highest_level_in_service;
        OCW2_SP_EOI: ocw2_eoi = num2bit(ocw2_level);
        OCW2_ROT_NS_EOI: begin
          ocw2_eoi = highest_level_in_service;
          if (|highest_level_in_service) begin
            ocw2_rot_valid = 1'b1;
            ocw2_rot_num   = bit2num(highest_level_in_service);
          end
        end
        OCW2_ROT_SP_EOI: begin
          ocw2_eoi       = num2bit(ocw2_level);
          ocw2_rot_valid = 1'b1;
          ocw2_rot_num   = ocw2_level;
        end
        OCW2_ROT_AEOI_SET: aeoi_rot_next = 1'b1;
        OCW2_ROT_AEOI_CLR: aeoi_rot_next = 1'b0;
        OCW2_SET_PRIO: begin
          ocw2_rot_valid = 1'b1;
          ocw2_rot_num   = ocw2_level;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_inta           <= 1'b1;
      state               <= ACK_IDLE;
      interrupt           <= 1'b0;
      latch_in_service    <= 1'b0;
      acknowledged_level  <= 8'h00;
      end_of_interrupt    <= 8'h00;
      priority_rotate     <= 3'd7;
      data_bus_out        <= 8'h00;
      data_bus_out_enable <= 1'b0;
      rotate_in_aeoi      <= 1'b0;
    end else begin
      prev_inta <= interrupt_acknowledge_n;
      if (icw1_write) begin
        state               <= ACK_IDLE;
        interrupt           <= 1'b0;
        latch_in_service    <= 1'b0;
        acknowledged_level  <= 8'h00;
        end_of_interrupt    <= 8'h00;
        priority_rotate     <= 3'd7;
        data_bus_out        <= 8'h00;
        data_bus_out_enable <= 1'b0;
        rotate_in_aeoi      <= 1'b0;
      end else begin
        latch_in_service <= 1'b0;
        end_of_interrupt <= ocw2_eoi;
        rotate_in_aeoi   <= aeoi_rot_next;
        if (ocw2_rot_valid) priority_rotate <= ocw2_rot_num;

        case (state)
          ACK_IDLE: begin
            if (inta_fall) begin
              interrupt          <= 1'b0;
              latch_in_service   <= |highest_level_in_request;
              acknowledged_level <= (|highest_level_in_request) ? highest_level_in_request
                                                                : num2bit(SPURIOUS_LEVEL);
              state              <= ACK_PULSE1;
              if (!mode_8086) begin
                data_bus_out        <= CALL_OPCODE;
                data_bus_out_enable <= 1'b1;
              end
            end else if (|highest_level_in_request) begin
              interrupt <= 1'b1;
            end
          end
          ACK_PULSE1: begin
            if (inta_fall) begin
              state               <= ACK_PULSE2;
              data_bus_out_enable <= 1'b1;
              if (mode_8086)            data_bus_out <= {vector_base, level_num};
              else if (call_interval_4) data_bus_out <= {call_address[2:0], level_num, 2'b00};
              else                      data_bus_out <= {call_address[2:1], level_num, 3'b000};
            end else if (inta_rise) begin
              data_bus_out        <= 8'h00;
              data_bus_out_enable <= 1'b0;
            end
          end
          ACK_PULSE2: begin
            if (inta_fall && !mode_8086) begin
              state               <= ACK_PULSE3;
              data_bus_out        <= call_address[10:3];
              data_bus_out_enable <= 1'b1;
            end else if (inta_rise) begin
              data_bus_out        <= 8'h00;
              data_bus_out_enable <= 1'b0;
            end
          end
          ACK_PULSE3: begin
            if (inta_rise) begin
              data_bus_out        <= 8'h00;
              data_bus_out_enable <= 1'b0;
            end
          end
          default: state <= ACK_IDLE;
        endcase

        // A rotate commanded through OCW2 in the same cycle takes precedence over AEOI rotation.
        if (seq_done) begin
          state <= ACK_IDLE;
          if (auto_eoi) begin
            end_of_interrupt <= ocw2_eoi | acknowledged_level;
            if (rotate_in_aeoi && !ocw2_rot_valid) priority_rotate <= level_num;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer_8259a.sv
// Self-checking bench: OCW2 vector table, directed INTA sequences and randomized sequences
// compared against a transaction-level model of the acknowledge protocol.
module tb_interrupt_ack_sequencer_8259a;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        icw1_write;
  logic        ocw2_write;
  logic [7:0]  ocw2_data;
  logic        mode_8086;
  logic        auto_eoi;
  logic        call_interval_4;
  logic [4:0]  vector_base;
  logic [10:0] call_address;
  logic        interrupt_acknowledge_n;
  logic [7:0]  highest_level_in_request;
  logic [7:0]  highest_level_in_service;
  logic        interrupt;
  logic        latch_in_service;
  logic [7:0]  acknowledged_level;
  logic [7:0]  end_of_interrupt;
  logic [2:0]  priority_rotate;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_enable;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_rotate;
  bit         m_rot_aeoi;

  typedef struct {
    logic [7:0] data;
    logic [7:0] isr;
    logic [7:0] exp_eoi;
    logic [2:0] exp_rotate;
  } ocw2_vec_t;

  ocw2_vec_t vecs[10];

  interrupt_ack_sequencer_8259a dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .icw1_write               (icw1_write),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .mode_8086                (mode_8086),
    .auto_eoi                 (auto_eoi),
    .call_interval_4          (call_interval_4),
    .vector_base              (vector_base),
    .call_address             (call_address),
    .interrupt_acknowledge_n  (interrupt_acknowledge_n),
    .highest_level_in_request (highest_level_in_request),
    .highest_level_in_service (highest_level_in_service),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .acknowledged_level       (acknowledged_level),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .data_bus_out             (data_bus_out),
    .data_bus_out_enable      (data_bus_out_enable)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got time limit expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic int onehot_index(input logic [7:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [7:0] rand_isr();
    return ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
  endfunction

  // OCW2 rules: EOI bit selects a target (specific L or the in-service level), R rotates to it.
  function automatic void model_ocw2(input logic [7:0] d, input logic [7:0] isr,
                                     output logic [7:0] eoi, output bit rot_valid,
                                     output logic [2:0] rot_num);
    bit r, sl, e;
    logic [7:0] target;
    r = d[7]; sl = d[6]; e = d[5];
    eoi = 8'h00; rot_valid = 0; rot_num = 3'd0;
    if (e) begin
      target = sl ? 8'(1 << d[2:0]) : isr;
      eoi = target;
      if (r && target != 0) begin
        rot_valid = 1;
        rot_num   = 3'(onehot_index(target));
      end
    end else if (r && sl) begin
      rot_valid = 1;
      rot_num   = d[2:0];
    end else if (r) begin
      m_rot_aeoi = 1;
    end else if (!sl) begin
      m_rot_aeoi = 0;
    end
  endfunction

  // Bytes the CPU expects: 8086 vector = base*8+level; 8080 routine address = call_address*32
  // plus level*interval, with A5 forced low for interval 8.
  function automatic void expected_byte(input int pulse, input int lvl, output bit drive,
                                        output logic [7:0] b);
    int addr;
    drive = 1;
    b = 8'h00;
    if (mode_8086) begin
      drive = (pulse == 2);
      b = 8'((int'(vector_base) * 8 + lvl) & 255);
    end else begin
      addr = int'(call_address) * 32;
      if (call_interval_4) addr = addr + lvl * 4;
      else                 addr = (addr & ~32) + lvl * 8;
      if (pulse == 1)      b = 8'hCD;
      else if (pulse == 2) b = 8'(addr & 255);
      else                 b = 8'((addr >> 8) & 255);
    end
  endfunction

  task automatic applyStimulus(input string name, input logic [7:0] d, input logic [7:0] isr);
    logic [7:0] e;
    bit rv;
    logic [2:0] rn;
    model_ocw2(d, isr, e, rv, rn);
    if (rv) m_rotate = rn;
    ocw2_write = 1; ocw2_data = d; highest_level_in_service = isr;
    tick();
    ocw2_write = 0;
    checkOutput({name, "_eoi"}, end_of_interrupt, e);
    checkOutput({name, "_rotate"}, 8'(priority_rotate), 8'(m_rotate));
    tick();
    checkOutput({name, "_eoi_pulse"}, end_of_interrupt, 8'h00);
  endtask

  task automatic ack_sequence(input string name, input logic [7:0] req, input int low_cycles,
                              input int high_cycles, input bit end_ocw2,
                              input logic [7:0] end_data, input logic [7:0] end_isr);
    int pulses, lvl;
    logic [7:0] lvl_mask, exp_eoi, oe;
    bit drive, rv, old_rot_aeoi;
    logic [7:0] b;
    logic [2:0] rn;
    pulses   = mode_8086 ? 2 : 3;
    lvl_mask = (req != 0) ? req : 8'h80;
    lvl      = onehot_index(lvl_mask);
    highest_level_in_request = req;
    tick();
    checkOutput({name, "_int_raise"}, 8'(interrupt), 8'(req != 0));
    for (int p = 1; p <= pulses; p++) begin
      interrupt_acknowledge_n = 0;
      expected_byte(p, lvl, drive, b);
      for (int c = 0; c < low_cycles; c++) begin
        tick();
        if (p == 1 && c == 0) begin
          checkOutput({name, "_int_drop"}, 8'(interrupt), 8'h00);
          checkOutput({name, "_latch"}, 8'(latch_in_service), 8'(req != 0));
          checkOutput({name, "_ack_level"}, acknowledged_level, lvl_mask);
          highest_level_in_request = 8'h00;
        end
        if (p == 1 && c == 1) checkOutput({name, "_latch_pulse"}, 8'(latch_in_service), 8'h00);
        checkOutput({name, "_oe"}, 8'(data_bus_out_enable), 8'(drive));
        if (drive) checkOutput({name, "_byte"}, data_bus_out, b);
      end
      interrupt_acknowledge_n = 1;
      if (p == pulses && end_ocw2) begin
        ocw2_write = 1; ocw2_data = end_data; highest_level_in_service = end_isr;
      end
      tick();
      ocw2_write = 0;
      oe = 8'(data_bus_out_enable);
      checkOutput({name, "_oe_release"}, oe, 8'h00);
      if (p == pulses) begin
        old_rot_aeoi = m_rot_aeoi;
        exp_eoi = 8'h00; rv = 0; rn = 3'd0;
        if (end_ocw2) model_ocw2(end_data, end_isr, exp_eoi, rv, rn);
        if (auto_eoi) exp_eoi = exp_eoi | lvl_mask;
        if (rv) m_rotate = rn;
        else if (auto_eoi && old_rot_aeoi) m_rotate = 3'(lvl);
        checkOutput({name, "_eoi"}, end_of_interrupt, exp_eoi);
        checkOutput({name, "_rotate"}, 8'(priority_rotate), 8'(m_rotate));
        tick();
        checkOutput({name, "_eoi_pulse"}, end_of_interrupt, 8'h00);
      end
      for (int c = 1; c < high_cycles; c++) tick();
    end
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_int"}, 8'(interrupt), 8'h00);
    checkOutput({name, "_latch"}, 8'(latch_in_service), 8'h00);
    checkOutput({name, "_level"}, acknowledged_level, 8'h00);
    checkOutput({name, "_eoi"}, end_of_interrupt, 8'h00);
    checkOutput({name, "_rotate"}, 8'(priority_rotate), 8'h07);
    checkOutput({name, "_dout"}, data_bus_out, 8'h00);
    checkOutput({name, "_oe"}, 8'(data_bus_out_enable), 8'h00);
  endtask

  initial begin
    vecs[0] = '{8'hE5, 8'h00, 8'h20, 3'd5};
    vecs[1] = '{8'h20, 8'h00, 8'h00, 3'd5};
    vecs[2] = '{8'h20, 8'h10, 8'h10, 3'd5};
    vecs[3] = '{8'h63, 8'h01, 8'h08, 3'd5};
    vecs[4] = '{8'hA0, 8'h40, 8'h40, 3'd6};
    vecs[5] = '{8'hA0, 8'h00, 8'h00, 3'd6};
    vecs[6] = '{8'hC2, 8'h01, 8'h00, 3'd2};
    vecs[7] = '{8'h40, 8'h04, 8'h00, 3'd2};
    vecs[8] = '{8'h80, 8'h00, 8'h00, 3'd2};
    vecs[9] = '{8'h00, 8'h00, 8'h00, 3'd2};

    reset_n = 0; icw1_write = 0; ocw2_write = 0; ocw2_data = 8'h00;
    mode_8086 = 1; auto_eoi = 0; call_interval_4 = 0; vector_base = 5'b01000;
    call_address = 11'h000; interrupt_acknowledge_n = 1;
    highest_level_in_request = 8'h00; highest_level_in_service = 8'h00;
    tick(); tick();
    check_reset_values("reset");
    reset_n = 1;
    tick();

    foreach (vecs[i]) begin
      ocw2_write = 1; ocw2_data = vecs[i].data; highest_level_in_service = vecs[i].isr;
      tick();
      ocw2_write = 0;
      checkOutput($sformatf("vec%0d_eoi", i), end_of_interrupt, vecs[i].exp_eoi);
      checkOutput($sformatf("vec%0d_rotate", i), 8'(priority_rotate), 8'(vecs[i].exp_rotate));
      tick();
      checkOutput($sformatf("vec%0d_eoi_pulse", i), end_of_interrupt, 8'h00);
    end
    m_rotate = 3'd2;
    m_rot_aeoi = 0;

    mode_8086 = 1; vector_base = 5'b01000; auto_eoi = 0;
    ack_sequence("x86_basic", 8'h08, 2, 2, 0, 8'h00, 8'h00);

    applyStimulus("set_rot_aeoi", 8'h80, 8'h00);
    auto_eoi = 1;
    ack_sequence("x86_aeoi_rot", 8'h08, 2, 2, 0, 8'h00, 8'h00);
    checkOutput("x86_aeoi_rot_is3", 8'(priority_rotate), 8'h03);

    mode_8086 = 0; auto_eoi = 0; call_interval_4 = 1; call_address = 11'h123;
    ack_sequence("i8080_adi4", 8'h04, 2, 2, 0, 8'h00, 8'h00);

    mode_8086 = 1; vector_base = 5'b10101;
    ack_sequence("spurious", 8'h00, 1, 1, 0, 8'h00, 8'h00);

    mode_8086 = 0; call_interval_4 = 0; auto_eoi = 1; call_address = 11'h5A7;
    ack_sequence("aeoi_plus_ocw2", 8'h02, 1, 2, 1, 8'hE4, 8'h00);

    mode_8086 = 1; auto_eoi = 0;
    highest_level_in_request = 8'h10;
    tick();
    interrupt_acknowledge_n = 0; tick();
    highest_level_in_request = 8'h00;
    interrupt_acknowledge_n = 1; tick();
    interrupt_acknowledge_n = 0; tick();
    checkOutput("mid_ack2_oe", 8'(data_bus_out_enable), 8'h01);
    reset_n = 0;
    #1;
    check_reset_values("async_reset");
    interrupt_acknowledge_n = 1;
    tick();
    reset_n = 1;
    tick();
    m_rotate = 3'd7; m_rot_aeoi = 0;
    ack_sequence("after_reset", 8'h01, 2, 1, 0, 8'h00, 8'h00);

    mode_8086 = 0;
    applyStimulus("prio1", 8'hC1, 8'h00);
    highest_level_in_request = 8'h20;
    tick();
    interrupt_acknowledge_n = 0; tick();
    highest_level_in_request = 8'h00;
    icw1_write = 1; tick();
    icw1_write = 0;
    check_reset_values("icw1");
    interrupt_acknowledge_n = 1; tick();
    m_rotate = 3'd7; m_rot_aeoi = 0;
    ack_sequence("after_icw1", 8'h40, 1, 1, 0, 8'h00, 8'h00);

    for (int it = 0; it < 40; it++) begin
      mode_8086 = 1'($urandom_range(0, 1));
      call_interval_4 = 1'($urandom_range(0, 1));
      auto_eoi = 1'($urandom_range(0, 1));
      vector_base = 5'($urandom);
      call_address = 11'($urandom);
      if ($urandom_range(0, 2) == 0) applyStimulus("rand_ocw2", 8'($urandom), rand_isr());
      ack_sequence($sformatf("rand%0d", it),
                   ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7)),
                   int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                   ($urandom_range(0, 3) == 0), 8'($urandom), rand_isr());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
